// File: rtl/text_fetch_sched.sv
// Text-mode fetch sequencer: tile RAM -> font ROM -> serial pixel bit.
// Shares the tile RAM port with a writer client; display has priority.
module text_fetch_sched #(
  parameter int COLS = 80,
  parameter int ROWS = 30,
  parameter int AW   = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pixel_tick,
  input  logic          video_on,
  input  logic          hsync_in,
  input  logic          vsync_in,
  input  logic [9:0]    pixel_x,
  input  logic [9:0]    pixel_y,
  output logic [AW-1:0] tram_addr,
  output logic          tram_we,
  output logic [6:0]    tram_wdata,
  input  logic [6:0]    tram_rdata,
  output logic [10:0]   rom_addr,
  input  logic [7:0]    font_word,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [6:0]    wr_data,
  output logic          wr_ack,
  output logic          wr_err,
  output logic          font_bit,
  output logic          video_on_out,
  output logic          hsync_out,
  output logic          vsync_out
);

  typedef enum logic [1:0] {IDLE, RD_T, RD_F} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   tram_addr_q, tram_addr_d;
  logic            tram_we_q, tram_we_d;
  logic [6:0]      tram_wdata_q, tram_wdata_d;
  logic [10:0]     rom_addr_q, rom_addr_d;
  logic [3:0]      line_q, line_d;
  logic [7:0]      word_buf_q, word_buf_d;
  logic            ack_c, err_c;

  logic [2:0]      xbit_q;
  logic            von_q, hs_q, vs_q;
  logic            font_bit_q, von_out_q, hs_out_q, vs_out_q;

  logic [6:0]      col;
  logic [4:0]      crow;
  logic [3:0]      line;
  logic            cell_start, in_range, wr_ok;
  logic [AW-1:0]   cell_addr;

  assign col        = pixel_x[9:3];
  assign crow       = pixel_y[8:4];
  assign line       = pixel_y[3:0];
  assign cell_start = pixel_tick & video_on & (pixel_x[2:0] == 3'd0);
  // rows at or beyond 512 are off-screen and must not alias onto row 0
  assign in_range   = ({1'b0, col} < 8'(COLS)) &&
                      ({1'b0, crow} < 6'(ROWS)) && !pixel_y[9];
  assign cell_addr  = AW'(crow) * AW'(COLS) + AW'(col);
  assign wr_ok      = {1'b0, wr_addr} < (AW+1)'(COLS * ROWS);

  always_comb begin
    state_d      = state_q;
    tram_addr_d  = tram_addr_q;
    tram_we_d    = 1'b0;
    tram_wdata_d = tram_wdata_q;
    rom_addr_d   = rom_addr_q;
    line_d       = line_q;
    word_buf_d   = word_buf_q;
    ack_c        = 1'b0;
    err_c        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cell_start) begin
          if (in_range) begin
            state_d     = RD_T;
            tram_addr_d = cell_addr;
            line_d      = line;
          end else begin
            word_buf_d  = '0;
          end
        end else if (wr_req) begin
          ack_c        = 1'b1;
          tram_addr_d  = wr_addr;
          tram_wdata_d = wr_data;
          tram_we_d    = wr_ok;
          err_c        = !wr_ok;
        end
      end
      RD_T: begin
        rom_addr_d = {tram_rdata, line_q};
        state_d    = RD_F;
      end
      RD_F: begin
        word_buf_d = font_word;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      tram_addr_q  <= '0;
      tram_we_q    <= 1'b0;
      tram_wdata_q <= '0;
      rom_addr_q   <= '0;
      line_q       <= '0;
      word_buf_q   <= '0;
    end else begin
      state_q      <= state_d;
      tram_addr_q  <= tram_addr_d;
      tram_we_q    <= tram_we_d;
      tram_wdata_q <= tram_wdata_d;
      rom_addr_q   <= rom_addr_d;
      line_q       <= line_d;
      word_buf_q   <= word_buf_d;
    end
  end

  // one-tick pixel pipeline keeps syncs aligned with font_bit
  always_ff @(posedge clk) begin
    if (reset) begin
      xbit_q     <= '0;
      von_q      <= 1'b0;
      hs_q       <= 1'b0;
      vs_q       <= 1'b0;
      font_bit_q <= 1'b0;
      von_out_q  <= 1'b0;
      hs_out_q   <= 1'b0;
      vs_out_q   <= 1'b0;
    end else if (pixel_tick) begin
      font_bit_q <= word_buf_q[~xbit_q] & von_q;
      von_out_q  <= von_q;
      hs_out_q   <= hs_q;
      vs_out_q   <= vs_q;
      xbit_q     <= pixel_x[2:0];
      von_q      <= video_on;
      hs_q       <= hsync_in;
      vs_q       <= vsync_in;
    end
  end

  assign tram_addr    = tram_addr_q;
  assign tram_we      = tram_we_q;
  assign tram_wdata   = tram_wdata_q;
  assign rom_addr     = rom_addr_q;
  assign wr_ack       = ack_c & ~reset;
  assign wr_err       = err_c & ~reset;
  assign font_bit     = font_bit_q;
  assign video_on_out = von_out_q;
  assign hsync_out    = hs_out_q;
  assign vsync_out    = vs_out_q;

endmodule

// File: tb/tb_text_fetch_sched.sv
// Directed bench for text_fetch_sched with tile RAM / font ROM models.
// Expected values are hand-computed from the cell/font contents below.
module tb_text_fetch_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pixel_tick = 1'b0;
  logic        video_on = 1'b0;
  logic        hsync_in = 1'b0;
  logic        vsync_in = 1'b0;
  logic [9:0]  pixel_x = '0;
  logic [9:0]  pixel_y = '0;
  logic [11:0] tram_addr;
  logic        tram_we;
  logic [6:0]  tram_wdata;
  logic [6:0]  tram_rdata;
  logic [10:0] rom_addr;
  logic [7:0]  font_word;
  logic        wr_req = 1'b0;
  logic [11:0] wr_addr = '0;
  logic [6:0]  wr_data = '0;
  logic        wr_ack, wr_err;
  logic        font_bit, video_on_out, hsync_out, vsync_out;

  logic [6:0]  tmem [0:4095];
  logic [7:0]  fmem [0:2047];
  int          we_cnt = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  text_fetch_sched dut (
    .clk(clk), .reset(reset), .pixel_tick(pixel_tick),
    .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .tram_addr(tram_addr), .tram_we(tram_we),
    .tram_wdata(tram_wdata), .tram_rdata(tram_rdata),
    .rom_addr(rom_addr), .font_word(font_word),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_err(wr_err), .font_bit(font_bit),
    .video_on_out(video_on_out), .hsync_out(hsync_out),
    .vsync_out(vsync_out)
  );

  always #5 clk = ~clk;

  assign tram_rdata = tmem[tram_addr];
  assign font_word  = fmem[rom_addr];

  always @(posedge clk) if (tram_we) we_cnt <= we_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input logic [9:0] x, input logic [9:0] y,
                      input logic von, input logic hs, input logic vs);
    @(negedge clk);
    pixel_x = x; pixel_y = y;
    video_on = von; hsync_in = hs; vsync_in = vs;
    pixel_tick = 1'b1;
    @(negedge clk);
    pixel_tick = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [7:0] fw;
    int bad, base, acks;
    fw = 8'hC3;
    for (int i = 0; i < 4096; i++) tmem[i] = '0;
    for (int i = 0; i < 2048; i++) fmem[i] = '0;
    tmem[165] = 7'h41;
    fmem[{7'h41, 4'd3}] = 8'hC3;

    // 1: reset with ticks and a pending writer
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      pixel_tick = (i % 4 == 0);
      video_on = 1'b1; pixel_x = 10'd40; pixel_y = 10'd35;
      hsync_in = 1'b1; vsync_in = 1'b1;
      wr_req = 1'b1; wr_addr = 12'd7; wr_data = 7'h11;
      #1;
      bad |= int'({font_bit, video_on_out, hsync_out, vsync_out,
                   tram_we, wr_ack, wr_err, (tram_addr != 0),
                   (rom_addr != 0), (tram_wdata != 0)});
    end
    check("rst_outs", bad, 0);
    @(negedge clk);
    reset = 1'b0; wr_req = 1'b0; pixel_tick = 1'b0;
    hsync_in = 1'b0; vsync_in = 1'b0;
    check("rst_we_cnt", we_cnt, 0);
    check("rst_tram_addr", tram_addr, 0);

    // 2: fetch of cell (2,5), line 3, then serialise
    tick(10'd40, 10'd35, 1'b1, 1'b0, 1'b0);
    check("fetch_tram_addr", tram_addr, 165);
    check("fetch_rom_addr", rom_addr, 11'h413);
    check("first_vout", video_on_out, 0);
    check("first_bit", font_bit, 0);
    for (int k = 1; k <= 9; k++) begin
      tick(10'(40 + k), 10'd35, (k < 8), (k == 4), 1'b0);
      check($sformatf("bit_k%0d", k), font_bit, (k <= 8) ? fw[8 - k] : 1'b0);
      check($sformatf("vout_k%0d", k), video_on_out, (k <= 8));
      if (k == 4 || k == 5)
        check($sformatf("hs_k%0d", k), hsync_out, (k == 5));
    end

    // 3: writer collides with a cell start; display goes first
    base = we_cnt;
    @(negedge clk);
    pixel_x = 10'd40; pixel_y = 10'd35; video_on = 1'b1;
    pixel_tick = 1'b1;
    wr_req = 1'b1; wr_addr = 12'd10; wr_data = 7'h20;
    #1 check("col_ack_c0", wr_ack, 0);
    @(negedge clk);
    pixel_tick = 1'b0; video_on = 1'b0;
    #1 check("col_ack_rdt", wr_ack, 0);
    check("col_addr_rdt", tram_addr, 165);
    check("col_we_rdt", tram_we, 0);
    @(negedge clk);
    #1 check("col_ack_rdf", wr_ack, 0);
    @(negedge clk);
    #1 check("col_ack_idle", wr_ack, 1);
    check("col_err_idle", wr_err, 0);
    @(negedge clk);
    wr_req = 1'b0;
    #1 check("col_we", tram_we, 1);
    check("col_waddr", tram_addr, 10);
    check("col_wdata", tram_wdata, 7'h20);
    check("col_ack_done", wr_ack, 0);
    @(negedge clk);
    #1 check("col_we_off", tram_we, 0);
    check("col_we_cnt", we_cnt - base, 1);

    // 4: out-of-range write address
    base = we_cnt;
    @(negedge clk);
    wr_req = 1'b1; wr_addr = 12'd2400; wr_data = 7'h05;
    #1 check("oor_ack", wr_ack, 1);
    check("oor_err", wr_err, 1);
    @(negedge clk);
    wr_req = 1'b0;
    #1 check("oor_we", tram_we, 0);
    check("oor_err_off", wr_err, 0);
    @(negedge clk);
    check("oor_we_cnt", we_cnt - base, 0);

    // 5: 16 back-to-back writes during blanking
    base = we_cnt;
    acks = 0;
    vsync_in = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      wr_req = 1'b1; wr_addr = 12'(100 + i); wr_data = 7'(8'h30 + i);
      #1 acks += int'(wr_ack);
      if (i > 0) begin
        check($sformatf("b2b_addr%0d", i - 1), tram_addr, 99 + i);
        check($sformatf("b2b_data%0d", i - 1), tram_data_of(tram_wdata),
              8'h2F + i);
      end
    end
    @(negedge clk);
    wr_req = 1'b0;
    #1 check("b2b_addr15", tram_addr, 115);
    check("b2b_data15", tram_wdata, 7'h3F);
    check("b2b_acks", acks, 16);
    @(negedge clk);
    check("b2b_we_cnt", we_cnt - base, 16);
    vsync_in = 1'b0;

    // 6: reset lands in RD_T of a fetch
    base = we_cnt;
    @(negedge clk);
    pixel_x = 10'd40; pixel_y = 10'd35; video_on = 1'b1;
    pixel_tick = 1'b1;
    wr_req = 1'b1; wr_addr = 12'd20; wr_data = 7'h11;
    @(negedge clk);
    pixel_tick = 1'b0; reset = 1'b1;
    #1 check("abort_ack", wr_ack, 0);
    @(negedge clk);
    reset = 1'b0; wr_req = 1'b0;
    #1 check("abort_we", tram_we, 0);
    check("abort_rom", rom_addr, 0);
    @(negedge clk);
    check("abort_we_cnt", we_cnt - base, 0);
    tick(10'd41, 10'd35, 1'b1, 1'b0, 1'b0);
    check("abort_bit1", font_bit, 0);
    tick(10'd42, 10'd35, 1'b1, 1'b0, 1'b0);
    check("abort_bit2", font_bit, 0);
    check("abort_vout", video_on_out, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  function automatic logic [7:0] tram_data_of(input logic [6:0] d);
    return {1'b0, d};
  endfunction

endmodule
